// File: rtl/rat_regfile_pkg.sv
// Shared types and sizes for the register alias table and its operand lookup.
package rat_regfile_pkg;

    localparam int unsigned ROB_TAG_W     = 4;
    localparam int unsigned NUM_ARCH_REGS = 32;

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;
    typedef logic [4:0]           arch_reg_t;

endpackage

// File: rtl/rat_regfile_src_lookup.sv
// Resolves one source operand to a value or a pending ROB tag.
module rat_src_lookup
    import rat_regfile_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = 4,
    parameter int unsigned CDB_COUNT = 4
) (
    input  arch_reg_t            rs_i,
    input  logic                 reg_busy_i,
    input  logic [ROB_DEPTH-1:0] reg_tag_i,
    input  logic [31:0]          reg_value_i,
    input  logic                 cdb_valid_i [CDB_COUNT],
    input  logic [ROB_DEPTH-1:0] cdb_rob_i   [CDB_COUNT],
    input  logic [31:0]          cdb_rd_v_i  [CDB_COUNT],
    input  logic                 rob_ready_i,
    input  logic [31:0]          rob_v_i,
    output logic                 busy_o,
    output logic [ROB_DEPTH-1:0] tag_o,
    output logic [31:0]          v_o,
    output logic [ROB_DEPTH-1:0] rob_tag_o
);

    logic        cdb_hit;
    logic [31:0] cdb_hit_v;

    // Lowest-numbered matching broadcast port wins.
    always_comb begin
        cdb_hit   = 1'b0;
        cdb_hit_v = '0;
        for (int i = 0; i < int'(CDB_COUNT); i++) begin
            if (!cdb_hit && cdb_valid_i[i] && (cdb_rob_i[i] == reg_tag_i)) begin
                cdb_hit   = 1'b1;
                cdb_hit_v = cdb_rd_v_i[i];
            end
        end
    end

    always_comb begin
        busy_o    = 1'b0;
        v_o       = '0;
        tag_o     = reg_tag_i;
        rob_tag_o = reg_tag_i;
        if (rs_i == '0) begin
            v_o = '0;
        end else if (!reg_busy_i) begin
            v_o = reg_value_i;
        end else if (cdb_hit) begin
            v_o = cdb_hit_v;
        end else if (rob_ready_i) begin
            v_o = rob_v_i;
        end else begin
            busy_o = 1'b1;
        end
    end

endmodule

// File: rtl/rat_regfile.sv
// Register alias table plus architectural register file: rename, commit and flush
// update the per-register state; two lookups resolve source operands.
module rat_regfile
    import rat_regfile_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = 4,
    parameter int unsigned CDB_COUNT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 rename_valid,
    input  arch_reg_t            rename_rd,
    input  logic [ROB_DEPTH-1:0] rename_rob,
    input  arch_reg_t            rename_rs1,
    input  arch_reg_t            rename_rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [ROB_DEPTH-1:0] rs1_tag,
    output logic [ROB_DEPTH-1:0] rs2_tag,
    output logic [31:0]          rs1_v,
    output logic [31:0]          rs2_v,
    output logic [ROB_DEPTH-1:0] rob_q1_tag,
    output logic [ROB_DEPTH-1:0] rob_q2_tag,
    input  logic                 rob_q1_ready,
    input  logic                 rob_q2_ready,
    input  logic [31:0]          rob_q1_v,
    input  logic [31:0]          rob_q2_v,
    input  logic                 cdb_valid [CDB_COUNT],
    input  logic [ROB_DEPTH-1:0] cdb_rob   [CDB_COUNT],
    input  logic [31:0]          cdb_rd_v  [CDB_COUNT],
    input  logic                 commit_valid,
    input  arch_reg_t            commit_rd,
    input  logic [ROB_DEPTH-1:0] commit_rob,
    input  logic [31:0]          commit_v
);

    // Entry 0 is never written, so it stays at its reset value of zero.
    logic [31:0]          value_q [NUM_ARCH_REGS];
    logic [31:0]          value_d [NUM_ARCH_REGS];
    logic                 busy_q  [NUM_ARCH_REGS];
    logic                 busy_d  [NUM_ARCH_REGS];
    logic [ROB_DEPTH-1:0] tag_q   [NUM_ARCH_REGS];
    logic [ROB_DEPTH-1:0] tag_d   [NUM_ARCH_REGS];

    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (commit_valid && (commit_rd != '0)) begin
            value_d[commit_rd] = commit_v;
            // A younger producer keeps the mapping.
            if (tag_q[commit_rd] == commit_rob) begin
                busy_d[commit_rd] = 1'b0;
            end
        end
        if (flush) begin
            for (int r = 0; r < int'(NUM_ARCH_REGS); r++) begin
                busy_d[r] = 1'b0;
            end
        end else if (rename_valid && (rename_rd != '0)) begin
            busy_d[rename_rd] = 1'b1;
            tag_d[rename_rd]  = rename_rob;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(NUM_ARCH_REGS); r++) begin
                value_q[r] <= '0;
                busy_q[r]  <= 1'b0;
                tag_q[r]   <= '0;
            end
        end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    rat_src_lookup #(
        .ROB_DEPTH (ROB_DEPTH),
        .CDB_COUNT (CDB_COUNT)
    ) u_src1 (
        .rs_i        (rename_rs1),
        .reg_busy_i  (busy_q[rename_rs1]),
        .reg_tag_i   (tag_q[rename_rs1]),
        .reg_value_i (value_q[rename_rs1]),
        .cdb_valid_i (cdb_valid),
        .cdb_rob_i   (cdb_rob),
        .cdb_rd_v_i  (cdb_rd_v),
        .rob_ready_i (rob_q1_ready),
        .rob_v_i     (rob_q1_v),
        .busy_o      (rs1_busy),
        .tag_o       (rs1_tag),
        .v_o         (rs1_v),
        .rob_tag_o   (rob_q1_tag)
    );

    rat_src_lookup #(
        .ROB_DEPTH (ROB_DEPTH),
        .CDB_COUNT (CDB_COUNT)
    ) u_src2 (
        .rs_i        (rename_rs2),
        .reg_busy_i  (busy_q[rename_rs2]),
        .reg_tag_i   (tag_q[rename_rs2]),
        .reg_value_i (value_q[rename_rs2]),
        .cdb_valid_i (cdb_valid),
        .cdb_rob_i   (cdb_rob),
        .cdb_rd_v_i  (cdb_rd_v),
        .rob_ready_i (rob_q2_ready),
        .rob_v_i     (rob_q2_v),
        .busy_o      (rs2_busy),
        .tag_o       (rs2_tag),
        .v_o         (rs2_v),
        .rob_tag_o   (rob_q2_tag)
    );

endmodule

// File: tb/tb_rat_regfile.sv
// Bench for rat_regfile: directed scenarios plus randomized traffic against a
// behavioural register-state model.
module tb_rat_regfile;
    import rat_regfile_pkg::*;

    localparam int unsigned RD = 4;
    localparam int unsigned CC = 4;

    logic          clk = 1'b0;
    logic          rst, flush, rename_valid;
    logic [4:0]    rename_rd, rename_rs1, rename_rs2;
    logic [RD-1:0] rename_rob;
    logic          rs1_busy, rs2_busy;
    logic [RD-1:0] rs1_tag, rs2_tag, rob_q1_tag, rob_q2_tag;
    logic [31:0]   rs1_v, rs2_v;
    logic          rob_q1_ready, rob_q2_ready;
    logic [31:0]   rob_q1_v, rob_q2_v;
    logic          cdb_valid [CC];
    logic [RD-1:0] cdb_rob   [CC];
    logic [31:0]   cdb_rd_v  [CC];
    logic          commit_valid;
    logic [4:0]    commit_rd;
    logic [RD-1:0] commit_rob;
    logic [31:0]   commit_v;

    int checks = 0;
    int failures = 0;

    // Behavioural state: what each architectural register holds.
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    rob_tag_t    m_tag  [32];

    always #5 clk = ~clk;

    rat_regfile #(.ROB_DEPTH(RD), .CDB_COUNT(CC)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .rename_valid (rename_valid),
        .rename_rd    (rename_rd),
        .rename_rob   (rename_rob),
        .rename_rs1   (rename_rs1),
        .rename_rs2   (rename_rs2),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rs1_tag      (rs1_tag),
        .rs2_tag      (rs2_tag),
        .rs1_v        (rs1_v),
        .rs2_v        (rs2_v),
        .rob_q1_tag   (rob_q1_tag),
        .rob_q2_tag   (rob_q2_tag),
        .rob_q1_ready (rob_q1_ready),
        .rob_q2_ready (rob_q2_ready),
        .rob_q1_v     (rob_q1_v),
        .rob_q2_v     (rob_q2_v),
        .cdb_valid    (cdb_valid),
        .cdb_rob      (cdb_rob),
        .cdb_rd_v     (cdb_rd_v),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_rob   (commit_rob),
        .commit_v     (commit_v)
    );

    function automatic void model_edge();
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
            end
            return;
        end
        if (commit_valid && commit_rd != 0) begin
            m_val[commit_rd] = commit_v;
            if (m_tag[commit_rd] == commit_rob) m_busy[commit_rd] = 1'b0;
        end
        if (flush) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        end else if (rename_valid && rename_rd != 0) begin
            m_busy[rename_rd] = 1'b1;
            m_tag[rename_rd]  = rename_rob;
        end
    endfunction

    function automatic void resolve(input logic [4:0] rs, input logic rdy, input logic [31:0] rv,
                                    output logic b, output logic [31:0] v);
        b = 1'b0;
        v = '0;
        if (rs == 0) return;
        if (!m_busy[rs]) begin v = m_val[rs]; return; end
        for (int i = 0; i < int'(CC); i++) begin
            if (cdb_valid[i] && cdb_rob[i] == m_tag[rs]) begin v = cdb_rd_v[i]; return; end
        end
        if (rdy) begin v = rv; return; end
        b = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; rename_valid = 1'b0; commit_valid = 1'b0;
        rename_rd = '0; rename_rob = '0; rename_rs1 = '0; rename_rs2 = '0;
        rob_q1_ready = 1'b0; rob_q2_ready = 1'b0; rob_q1_v = '0; rob_q2_v = '0;
        commit_rd = '0; commit_rob = '0; commit_v = '0;
        for (int i = 0; i < int'(CC); i++) begin
            cdb_valid[i] = 1'b0; cdb_rob[i] = '0; cdb_rd_v[i] = '0;
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; flush = 1'b1; rename_valid = 1'b1; rename_rd = 5'd5; rename_rob = 4'd3;
        tick(); tick();
        idle();
        rename_rs1 = 5'd5; rename_rs2 = 5'd0;
        #3;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_v !== 32'h0) begin
            failures++; $display("FAIL reset_rs1 got busy=%b v=%h want busy=0 v=0", rs1_busy, rs1_v);
        end
        checks++;
        if (rs2_busy !== 1'b0 || rs2_v !== 32'h0) begin
            failures++; $display("FAIL reset_rs2 got busy=%b v=%h want busy=0 v=0", rs2_busy, rs2_v);
        end
        checks++;
        if (rs1_tag !== '0 || rob_q1_tag !== '0 || rob_q2_tag !== '0) begin
            failures++;
            $display("FAIL reset_tags got %h %h %h want 0", rs1_tag, rob_q1_tag, rob_q2_tag);
        end
    endtask

    task automatic test_rename();
        rename_valid = 1'b1; rename_rd = 5'd3; rename_rob = 4'd7; rename_rs1 = 5'd3;
        #3;
        checks++;  // same-cycle read returns the old mapping
        if (rs1_busy !== 1'b0) begin
            failures++; $display("FAIL rename_old_map got busy=%b want 0", rs1_busy);
        end
        tick();
        idle();
        rename_rs1 = 5'd3;
        #3;
        checks++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd7 || rob_q1_tag !== 4'd7) begin
            failures++;
            $display("FAIL rename_busy got busy=%b tag=%h q=%h want 1 7 7", rs1_busy, rs1_tag, rob_q1_tag);
        end
    endtask

    task automatic test_cdb_bypass();
        rename_rs1 = 5'd3;
        cdb_valid[2] = 1'b1; cdb_rob[2] = 4'd7; cdb_rd_v[2] = 32'hDEADBEEF;
        cdb_valid[3] = 1'b1; cdb_rob[3] = 4'd7; cdb_rd_v[3] = 32'h12345678;
        rob_q1_ready = 1'b1; rob_q1_v = 32'hAAAA5555;
        #3;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_v !== 32'hDEADBEEF) begin
            failures++; $display("FAIL cdb_bypass got busy=%b v=%h want 0 deadbeef", rs1_busy, rs1_v);
        end
        cdb_valid[2] = 1'b0; cdb_valid[3] = 1'b0;
        #2;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_v !== 32'hAAAA5555) begin
            failures++; $display("FAIL rob_bypass got busy=%b v=%h want 0 aaaa5555", rs1_busy, rs1_v);
        end
        cdb_valid[2] = 1'b1;
        tick();
        idle();
        rename_rs1 = 5'd3;
        #3;
        checks++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd7) begin
            failures++; $display("FAIL cdb_no_state got busy=%b tag=%h want 1 7", rs1_busy, rs1_tag);
        end
    endtask

    task automatic test_commit_younger();
        rename_valid = 1'b1; rename_rd = 5'd4; rename_rob = 4'd2;
        tick();
        rename_rob = 4'd5;
        tick();
        idle();
        commit_valid = 1'b1; commit_rd = 5'd4; commit_rob = 4'd2; commit_v = 32'h11;
        tick();
        idle();
        rename_rs1 = 5'd4;
        #3;
        checks++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd5) begin
            failures++; $display("FAIL commit_older got busy=%b tag=%h want 1 5", rs1_busy, rs1_tag);
        end
        commit_valid = 1'b1; commit_rd = 5'd4; commit_rob = 4'd5; commit_v = 32'h22;
        tick();
        idle();
        rename_rs1 = 5'd4;
        #3;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_v !== 32'h22) begin
            failures++; $display("FAIL commit_current got busy=%b v=%h want 0 22", rs1_busy, rs1_v);
        end
    endtask

    task automatic test_back_to_back();
        rename_valid = 1'b1; rename_rd = 5'd6; rename_rob = 4'd1;
        tick();
        idle();
        rename_valid = 1'b1; rename_rd = 5'd6; rename_rob = 4'd9;
        commit_valid = 1'b1; commit_rd = 5'd6; commit_rob = 4'd1; commit_v = 32'h33;
        tick();
        idle();
        rename_rs2 = 5'd6;
        #3;
        checks++;
        if (rs2_busy !== 1'b1 || rs2_tag !== 4'd9 || rob_q2_tag !== 4'd9) begin
            failures++;
            $display("FAIL same_cycle got busy=%b tag=%h q=%h want 1 9 9", rs2_busy, rs2_tag, rob_q2_tag);
        end
    endtask

    task automatic test_flush();
        rename_valid = 1'b1; rename_rd = 5'd11; rename_rob = 4'd3;
        tick();
        rename_rd = 5'd12; rename_rob = 4'd4;
        tick();
        idle();
        flush = 1'b1;
        commit_valid = 1'b1; commit_rd = 5'd8; commit_rob = 4'd0; commit_v = 32'h44;
        rename_valid = 1'b1; rename_rd = 5'd10; rename_rob = 4'd6;
        tick();
        idle();
        rename_rs1 = 5'd8; rename_rs2 = 5'd10;
        #3;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_v !== 32'h44) begin
            failures++; $display("FAIL flush_commit got busy=%b v=%h want 0 44", rs1_busy, rs1_v);
        end
        checks++;
        if (rs2_busy !== 1'b0 || rs2_v !== 32'h0) begin
            failures++; $display("FAIL flush_rename got busy=%b v=%h want 0 0", rs2_busy, rs2_v);
        end
        rename_rs1 = 5'd6; rename_rs2 = 5'd12;
        #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_v !== 32'h33) begin
            failures++; $display("FAIL flush_keep_val got busy=%b v=%h want 0 33", rs1_busy, rs1_v);
        end
        checks++;
        if (rs2_busy !== 1'b0) begin
            failures++; $display("FAIL flush_clear got busy=%b want 0", rs2_busy);
        end
    endtask

    task automatic test_random();
        logic        eb;
        logic [31:0] ev;
        for (int n = 0; n < 400; n++) begin
            idle();
            rst          = ($urandom_range(0, 99) == 0);
            flush        = ($urandom_range(0, 24) == 0);
            rename_valid = $urandom_range(0, 1) == 1;
            rename_rd    = 5'($urandom_range(0, 15));
            rename_rob   = 4'($urandom);
            commit_valid = $urandom_range(0, 2) != 0;
            commit_rd    = 5'($urandom_range(0, 15));
            commit_rob   = ($urandom_range(0, 1) == 1) ? m_tag[commit_rd] : 4'($urandom);
            commit_v     = $urandom;
            rename_rs1   = 5'($urandom_range(0, 15));
            rename_rs2   = 5'($urandom_range(0, 15));
            rob_q1_ready = ($urandom_range(0, 3) == 0);
            rob_q2_ready = ($urandom_range(0, 3) == 0);
            rob_q1_v     = $urandom;
            rob_q2_v     = $urandom;
            for (int i = 0; i < int'(CC); i++) begin
                cdb_valid[i] = ($urandom_range(0, 2) == 0);
                cdb_rob[i]   = 4'($urandom_range(0, 7));
                cdb_rd_v[i]  = $urandom;
            end
            #3;
            resolve(rename_rs1, rob_q1_ready, rob_q1_v, eb, ev);
            checks++;
            if (rs1_busy !== eb || (!eb && rs1_v !== ev) || (eb && rs1_tag !== m_tag[rename_rs1])) begin
                failures++;
                $display("FAIL rand_rs1 n=%0d rs=%0d got b=%b v=%h t=%h want b=%b v=%h t=%h", n,
                         rename_rs1, rs1_busy, rs1_v, rs1_tag, eb, ev, m_tag[rename_rs1]);
            end
            resolve(rename_rs2, rob_q2_ready, rob_q2_v, eb, ev);
            checks++;
            if (rs2_busy !== eb || (!eb && rs2_v !== ev) || (eb && rs2_tag !== m_tag[rename_rs2])) begin
                failures++;
                $display("FAIL rand_rs2 n=%0d rs=%0d got b=%b v=%h t=%h want b=%b v=%h t=%h", n,
                         rename_rs2, rs2_busy, rs2_v, rs2_tag, eb, ev, m_tag[rename_rs2]);
            end
            checks++;
            if (rob_q1_tag !== m_tag[rename_rs1] || rob_q2_tag !== m_tag[rename_rs2]) begin
                failures++;
                $display("FAIL rand_robq n=%0d got %h %h want %h %h", n, rob_q1_tag, rob_q2_tag,
                         m_tag[rename_rs1], m_tag[rename_rs2]);
            end
            tick();
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
        end
        idle();
        test_reset();
        test_rename();
        test_cdb_bypass();
        test_commit_younger();
        test_back_to_back();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
